// File: rtl/r4_stage_rx_align_pkg.sv
// ---------------------------------------------------------------------------
// r4_stage_rx_align_pkg
// Shared definitions for the radix-4 receive-side terminator:
//   - mantissa / exponent widths (MAN_WIDTH / EXP_WIDTH, defaulted here when
//     the fixed-point header has not already defined them)
//   - sample index width
//   - stage-1 tag record carried alongside each sample
//   - segment length lookup S(ldn) (4 for even ldn, 8 for odd ldn), the same
//     rule the butterfly units use
//   - frame length N(ldn) = 1 << ldn
// Symmetric rounding (half away from zero) is applied in bfp_shift_sat.
// ---------------------------------------------------------------------------
`ifndef MAN_WIDTH
`define MAN_WIDTH 16
`endif
`ifndef EXP_WIDTH
`define EXP_WIDTH 6
`endif

package r4_stage_rx_align_pkg;

  localparam int MAN_W = `MAN_WIDTH;
  localparam int EXP_W = `EXP_WIDTH;
  localparam int IDX_W = 11;

  // Per-sample control travelling with the data through stage 1.
  typedef struct packed {
    logic             val;
    logic             sop;
    logic             eop;
    logic             k1;
    logic             k2;
    logic [IDX_W-1:0] idx;
  } tag_t;

  // Segment length: radix-2 tail stage doubles the segment for odd ldn.
  function automatic logic [3:0] seg_len(input logic [3:0] ldn);
    if (ldn[0]) begin
      return 4'd8;
    end else begin
      return 4'd4;
    end
  endfunction

  // Frame length N = 1 << ldn (one bit wider than the index).
  function automatic logic [IDX_W:0] frame_len(input logic [3:0] ldn);
    return {{IDX_W{1'b0}}, 1'b1} << ldn;
  endfunction

endpackage

// File: rtl/r4_stage_rx_align_bfp_shift_sat.sv
// ---------------------------------------------------------------------------
// bfp_shift_sat
// Combinational block-floating-point to fixed-point converter for a single
// component.
//   man  in  MAN_W      signed mantissa
//   sh   in  EXP_W+1    signed shift (target exponent - sample exponent)
//   res  out OUT_WIDTH  signed result, symmetric saturation
//   sat  out 1          result was clipped
// sh > 0 : arithmetic right shift with rounding half away from zero; any
//          shift of MAN_W+1 or more leaves nothing (result 0).
// sh <= 0: left shift by -sh.
// The conversion works on the magnitude so rounding and clipping are
// symmetric and -2^(OUT_WIDTH-1) can never be produced.
// ---------------------------------------------------------------------------
module bfp_shift_sat
  import r4_stage_rx_align_pkg::*;
#(
  parameter int OUT_WIDTH = 16
) (
  input  logic signed [MAN_W-1:0]     man,
  input  logic signed [EXP_W:0]       sh,
  output logic signed [OUT_WIDTH-1:0] res,
  output logic                        sat
);

  // Wide enough for |man| << (OUT_WIDTH-1) plus rounding carry.
  localparam int WW = MAN_W + OUT_WIDTH + 2;
  localparam logic [EXP_W:0]  RSH_ZERO = (EXP_W+1)'(MAN_W + 1);
  localparam logic [EXP_W:0]  LSH_SAT  = (EXP_W+1)'(OUT_WIDTH);
  localparam logic [WW-1:0]   LIM      = {{(WW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [WW-1:0]   ONE_W    = {{(WW-1){1'b0}}, 1'b1};
  localparam logic [EXP_W:0]  ONE_A    = {{EXP_W{1'b0}}, 1'b1};

  logic                 neg_s;
  logic                 rsh_s;
  logic [MAN_W:0]       mag_s;
  logic [EXP_W:0]       amt_s;
  logic [WW-1:0]        mag_w_s;
  logic [WW-1:0]        shifted_s;
  logic [WW-1:0]        res_mag_s;
  logic [OUT_WIDTH-1:0] res_u_s;

  // Magnitude shift, round, clip, then restore the sign.
  always_comb begin
    neg_s   = man[MAN_W-1];
    mag_s   = neg_s ? (-{man[MAN_W-1], man}) : {1'b0, man};
    mag_w_s = {{(OUT_WIDTH+1){1'b0}}, mag_s};
    rsh_s   = !sh[EXP_W] && (|sh);
    amt_s   = sh[EXP_W] ? (-sh) : sh;
    if (rsh_s) begin
      if (amt_s >= RSH_ZERO) begin
        shifted_s = {WW{1'b0}};
      end else begin
        shifted_s = (mag_w_s + (ONE_W << (amt_s - ONE_A))) >> amt_s;
      end
    end else if (amt_s >= LSH_SAT) begin
      // Any non-zero mantissa shifted this far is out of range.
      shifted_s = (mag_s == {(MAN_W+1){1'b0}}) ? {WW{1'b0}} : {WW{1'b1}};
    end else begin
      shifted_s = mag_w_s << amt_s;
    end
    sat       = (shifted_s > LIM);
    res_mag_s = sat ? LIM : shifted_s;
    res_u_s   = res_mag_s[OUT_WIDTH-1:0];
    res       = neg_s ? (-res_u_s) : res_u_s;
  end

endmodule

// File: rtl/r4_stage_rx_align.sv
// ---------------------------------------------------------------------------
// r4_stage_rx_align
// Receive-side terminator for the radix-4 pipeline output stream. Checks
// frame/segment framing, numbers each sample within its frame and converts
// block-floating-point samples to OUT_WIDTH fixed point at tgt_exp_i.
// Latency is 2 clk_sys cycles: stage 1 registers sample/tag/shift, stage 2
// registers the rounded and saturated result.
//
// Ports
//   clk_sys, rst_sys_n (async, active-low)
//   block_sync_i, stage_sync_i, data_val_i, k1_i, k2_i   input stream control
//   data_real_i, data_imag_i (MAN_W), data_exp_i (EXP_W) input sample
//   ldn_rg_i (4)   log2 frame length, tgt_exp_i (EXP_W) target exponent
//   err_clr_i      clears sync_err_o
//   data_val_o, sop_o, eop_o, data_real_o, data_imag_o (OUT_WIDTH),
//   sample_idx_o (11), k1_o, k2_o, sat_o, sync_err_o (sticky)
//   sat_cnt_o (12)  only with FFT_RX_SATCNT_EN: saturated samples in the
//                   last completed frame
// Build option: define FFT_RX_SATCNT_EN to add the saturation counter.
// ---------------------------------------------------------------------------
module r4_stage_rx_align
  import r4_stage_rx_align_pkg::*;
#(
  parameter int OUT_WIDTH = 16
) (
  input  logic                        clk_sys,
  input  logic                        rst_sys_n,
  input  logic                        block_sync_i,
  input  logic                        stage_sync_i,
  input  logic                        data_val_i,
  input  logic signed [MAN_W-1:0]     data_real_i,
  input  logic signed [MAN_W-1:0]     data_imag_i,
  input  logic signed [EXP_W-1:0]     data_exp_i,
  input  logic                        k1_i,
  input  logic                        k2_i,
  input  logic [3:0]                  ldn_rg_i,
  input  logic signed [EXP_W-1:0]     tgt_exp_i,
  input  logic                        err_clr_i,
  output logic                        data_val_o,
  output logic                        sop_o,
  output logic                        eop_o,
  output logic signed [OUT_WIDTH-1:0] data_real_o,
  output logic signed [OUT_WIDTH-1:0] data_imag_o,
  output logic [IDX_W-1:0]            sample_idx_o,
  output logic                        k1_o,
  output logic                        k2_o,
  output logic                        sat_o,
  output logic                        sync_err_o
`ifdef FFT_RX_SATCNT_EN
  ,
  output logic [11:0]                 sat_cnt_o
`endif
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]                  state_r, state_s;
  logic [IDX_W-1:0]            idx_r, idx_s, cur_idx_s;
  logic [IDX_W:0]              last_idx_s;
  logic [3:0]                  seg_s;
  logic                        accept_s, eop_s, err_s, seg_start_s, seg_odd_s;
  logic signed [EXP_W:0]       sh_s;

  tag_t                        s1_tag_r;
  logic signed [MAN_W-1:0]     s1_real_r, s1_imag_r;
  logic signed [EXP_W:0]       s1_sh_r;

  logic signed [OUT_WIDTH-1:0] re_s, im_s;
  logic                        re_sat_s, im_sat_s, sat_any_s;

  // Frame tracking, framing checks and next-state decode.
  always_comb begin
    seg_s       = seg_len(ldn_rg_i);
    last_idx_s  = frame_len(ldn_rg_i) - {{IDX_W{1'b0}}, 1'b1};
    // block_sync always (re)starts numbering at 0.
    cur_idx_s   = block_sync_i ? {IDX_W{1'b0}} : idx_r;
    accept_s    = data_val_i && (block_sync_i || (state_r == ST_RUN));
    eop_s       = accept_s && ({1'b0, cur_idx_s} == last_idx_s);
    seg_start_s = ((cur_idx_s[3:0] & (seg_s - 4'd1)) == 4'd0);
    // Bit 0 of idx/S is the idx bit weighted S.
    seg_odd_s   = ((cur_idx_s[3:0] & seg_s) != 4'd0);
    sh_s        = {tgt_exp_i[EXP_W-1], tgt_exp_i} - {data_exp_i[EXP_W-1], data_exp_i};

    if (accept_s) begin
      if (eop_s) begin
        state_s = ST_IDLE;
        idx_s   = {IDX_W{1'b0}};
      end else begin
        state_s = ST_RUN;
        idx_s   = cur_idx_s + {{(IDX_W-1){1'b0}}, 1'b1};
      end
    end else begin
      state_s = state_r;
      idx_s   = idx_r;
    end

    if (block_sync_i && !data_val_i) begin
      err_s = 1'b1;
    end else if (data_val_i && (state_r == ST_RUN)) begin
      if (block_sync_i && (idx_r != {IDX_W{1'b0}})) begin
        err_s = 1'b1;
      end else if ((stage_sync_i != seg_start_s) || (k2_i != seg_odd_s)) begin
        err_s = 1'b1;
      end else begin
        err_s = 1'b0;
      end
    end else begin
      err_s = 1'b0;
    end
  end

  // Frame state, index counter and sticky error (new error beats clear).
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_r    <= ST_IDLE;
      idx_r      <= {IDX_W{1'b0}};
      sync_err_o <= 1'b0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      sync_err_o <= err_s | (sync_err_o & ~err_clr_i);
    end
  end

  // Stage 1: capture accepted sample, its tag and the shift amount.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      s1_tag_r  <= '{val: 1'b0, sop: 1'b0, eop: 1'b0, k1: 1'b0, k2: 1'b0, idx: {IDX_W{1'b0}}};
      s1_real_r <= {MAN_W{1'b0}};
      s1_imag_r <= {MAN_W{1'b0}};
      s1_sh_r   <= {(EXP_W+1){1'b0}};
    end else if (accept_s) begin
      s1_tag_r  <= '{val: 1'b1, sop: block_sync_i, eop: eop_s, k1: k1_i, k2: k2_i, idx: cur_idx_s};
      s1_real_r <= data_real_i;
      s1_imag_r <= data_imag_i;
      s1_sh_r   <= sh_s;
    end else begin
      s1_tag_r.val <= 1'b0;
    end
  end

  bfp_shift_sat #(.OUT_WIDTH(OUT_WIDTH)) u_conv_re (
    .man (s1_real_r),
    .sh  (s1_sh_r),
    .res (re_s),
    .sat (re_sat_s)
  );

  bfp_shift_sat #(.OUT_WIDTH(OUT_WIDTH)) u_conv_im (
    .man (s1_imag_r),
    .sh  (s1_sh_r),
    .res (im_s),
    .sat (im_sat_s)
  );

  assign sat_any_s = re_sat_s | im_sat_s;

  // Stage 2: registered outputs; data fields hold between valid samples.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      data_val_o   <= 1'b0;
      sop_o        <= 1'b0;
      eop_o        <= 1'b0;
      data_real_o  <= {OUT_WIDTH{1'b0}};
      data_imag_o  <= {OUT_WIDTH{1'b0}};
      sample_idx_o <= {IDX_W{1'b0}};
      k1_o         <= 1'b0;
      k2_o         <= 1'b0;
      sat_o        <= 1'b0;
    end else if (s1_tag_r.val) begin
      data_val_o   <= 1'b1;
      sop_o        <= s1_tag_r.sop;
      eop_o        <= s1_tag_r.eop;
      data_real_o  <= re_s;
      data_imag_o  <= im_s;
      sample_idx_o <= s1_tag_r.idx;
      k1_o         <= s1_tag_r.k1;
      k2_o         <= s1_tag_r.k2;
      sat_o        <= sat_any_s;
    end else begin
      data_val_o   <= 1'b0;
      sop_o        <= 1'b0;
      eop_o        <= 1'b0;
      sat_o        <= 1'b0;
    end
  end

`ifdef FFT_RX_SATCNT_EN
  logic [11:0] sat_run_r, sat_run_s;

  // Running count for the current frame, restarting on sop, clipped at 4095.
  always_comb begin
    sat_run_s = s1_tag_r.sop ? 12'd0 : sat_run_r;
    if (sat_any_s && (sat_run_s != 12'hFFF)) begin
      sat_run_s = sat_run_s + 12'd1;
    end else begin
      sat_run_s = sat_run_s;
    end
  end

  // Count advances per valid sample; published when the eop sample leaves.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      sat_run_r <= 12'd0;
      sat_cnt_o <= 12'd0;
    end else if (s1_tag_r.val) begin
      sat_run_r <= sat_run_s;
      if (s1_tag_r.eop) begin
        sat_cnt_o <= sat_run_s;
      end else begin
        sat_cnt_o <= sat_cnt_o;
      end
    end else begin
      sat_run_r <= sat_run_r;
      sat_cnt_o <= sat_cnt_o;
    end
  end
`else
  // Saturation counter not built.
`endif

endmodule

// File: tb/tb_r4_stage_rx_align.sv
// ---------------------------------------------------------------------------
// tb_r4_stage_rx_align
// Directed self-checking bench for r4_stage_rx_align (MAN 16, EXP 6, OUT 16).
// Each tick drives one input cycle and records the hand-computed expected
// output; outputs are compared two ticks later, sync_err_o one tick later.
// ---------------------------------------------------------------------------
module tb_r4_stage_rx_align;
  import r4_stage_rx_align_pkg::*;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic                    rst_sys_n;
  logic                    block_sync_i, stage_sync_i, data_val_i;
  logic signed [MAN_W-1:0] data_real_i, data_imag_i;
  logic signed [EXP_W-1:0] data_exp_i;
  logic                    k1_i, k2_i;
  logic [3:0]              ldn_rg_i;
  logic signed [EXP_W-1:0] tgt_exp_i;
  logic                    err_clr_i;
  logic                    data_val_o, sop_o, eop_o;
  logic signed [15:0]      data_real_o, data_imag_o;
  logic [IDX_W-1:0]        sample_idx_o;
  logic                    k1_o, k2_o, sat_o, sync_err_o;
`ifdef FFT_RX_SATCNT_EN
  logic [11:0]             sat_cnt_o;
`endif

  r4_stage_rx_align #(.OUT_WIDTH(16)) dut (
    .clk_sys      (clk_sys),
    .rst_sys_n    (rst_sys_n),
    .block_sync_i (block_sync_i),
    .stage_sync_i (stage_sync_i),
    .data_val_i   (data_val_i),
    .data_real_i  (data_real_i),
    .data_imag_i  (data_imag_i),
    .data_exp_i   (data_exp_i),
    .k1_i         (k1_i),
    .k2_i         (k2_i),
    .ldn_rg_i     (ldn_rg_i),
    .tgt_exp_i    (tgt_exp_i),
    .err_clr_i    (err_clr_i),
    .data_val_o   (data_val_o),
    .sop_o        (sop_o),
    .eop_o        (eop_o),
    .data_real_o  (data_real_o),
    .data_imag_o  (data_imag_o),
    .sample_idx_o (sample_idx_o),
    .k1_o         (k1_o),
    .k2_o         (k2_o),
    .sat_o        (sat_o),
    .sync_err_o   (sync_err_o)
`ifdef FFT_RX_SATCNT_EN
    ,
    .sat_cnt_o    (sat_cnt_o)
`endif
  );

  typedef struct packed {
    logic        val;
    logic        sop;
    logic        eop;
    logic        k1;
    logic        k2;
    logic        sat;
    logic        err;
    logic [10:0] idx;
    logic [15:0] re;
    logic [15:0] im;
  } exp_t;

  exp_t p1, p2;
  int   n_total = 0;
  int   n_bad   = 0;

  // Conversion frame: per-sample exponent, inputs and expected results (tgt=3).
  int f2_ex  [16] = '{1, 1, 3, 5, 5, -31, -13, -12, 31, 17, 2, 2, 3, 3, 3, 3};
  int f2_re  [16] = '{7, -6, -32768, 10000, 0, 32767, -32768, 16384, 1, 1, -3, -1, 1000, -1000, 32767, -32767};
  int f2_im  [16] = '{5, -2, 100, -10000, 3, -32768, 32767, 16383, 0, -2, 3, 1, 12, 13, 14, 15};
  int f2_ere [16] = '{2, -2, -32767, 32767, 0, 0, -1, 1, 32767, 16384, -2, -1, 1000, -1000, 32767, -32767};
  int f2_eim [16] = '{1, -1, 100, -32767, 12, 0, 0, 0, 0, -32767, 2, 1, 12, 13, 14, 15};
  int f2_sat [16] = '{0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};

  task automatic chk_eq(input string tag, input logic signed [31:0] got, input logic signed [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic exp_t mk(input logic val, input logic sop, input logic eop, input logic k1,
                              input logic k2, input logic sat, input logic err,
                              input int idx, input int re, input int im);
    exp_t e;
    e.val = val; e.sop = sop; e.eop = eop; e.k1 = k1; e.k2 = k2;
    e.sat = sat; e.err = err; e.idx = 11'(idx); e.re = 16'(re); e.im = 16'(im);
    return e;
  endfunction

  task automatic tick(input logic bs, input logic ss, input logic dv, input logic k1, input logic k2,
                      input int re, input int im, input int ex, input logic clr, input exp_t e);
    @(posedge clk_sys);
    #1;
    block_sync_i = bs; stage_sync_i = ss; data_val_i = dv; k1_i = k1; k2_i = k2;
    data_real_i = 16'(re); data_imag_i = 16'(im); data_exp_i = 6'(ex); err_clr_i = clr;
    @(negedge clk_sys);
    chk_eq("val", data_val_o, p2.val);
    if (p2.val) begin
      chk_eq("sop",  sop_o, p2.sop);
      chk_eq("eop",  eop_o, p2.eop);
      chk_eq("re",   data_real_o, $signed(p2.re));
      chk_eq("im",   data_imag_o, $signed(p2.im));
      chk_eq("idx",  sample_idx_o, p2.idx);
      chk_eq("k1",   k1_o, p2.k1);
      chk_eq("k2",   k2_o, p2.k2);
      chk_eq("sat",  sat_o, p2.sat);
    end
    chk_eq("sync_err", sync_err_o, p1.err);
    p2 = p1;
    p1 = e;
  endtask

  task automatic idle(input logic clr, input logic err);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, clr, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, err, 0, 0, 0));
  endtask

  // Well-framed frame at sh=0 (identity); optionally drop stage_sync at one idx.
  task automatic fr_std(input int n, input int s, input int miss);
    for (int i = 0; i < n; i++) begin
      logic ss, k2, k1, er;
      int   re, im;
      ss = ((i % s) == 0) && (i != miss);
      k2 = ((i / s) % 2) == 1;
      k1 = (i % 2) == 1;
      er = (miss >= 0) && (i >= miss);
      re = i * 37 - 500;
      im = 300 - i * 11;
      tick(i == 0, ss, 1'b1, k1, k2, re, im, 0, 1'b0,
           mk(1'b1, i == 0, i == n - 1, k1, k2, 1'b0, er, i, re, im));
    end
  endtask

  initial begin
    rst_sys_n = 1'b0;
    block_sync_i = 1'b0; stage_sync_i = 1'b0; data_val_i = 1'b0;
    data_real_i = 16'sd0; data_imag_i = 16'sd0; data_exp_i = 6'sd0;
    k1_i = 1'b0; k2_i = 1'b0; ldn_rg_i = 4'd4; tgt_exp_i = 6'sd0; err_clr_i = 1'b0;
    p1 = '0; p2 = '0;

    // Reset state.
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    chk_eq("rst_val", data_val_o, 1'b0);
    chk_eq("rst_sop", sop_o, 1'b0);
    chk_eq("rst_eop", eop_o, 1'b0);
    chk_eq("rst_re", data_real_o, 0);
    chk_eq("rst_im", data_imag_o, 0);
    chk_eq("rst_idx", sample_idx_o, 0);
    chk_eq("rst_sat", sat_o, 1'b0);
    chk_eq("rst_err", sync_err_o, 1'b0);
    @(posedge clk_sys);
    #1 rst_sys_n = 1'b1;

    // Frame 1: ldn=4, identity.
    fr_std(16, 4, -1);
    repeat (3) idle(1'b0, 1'b0);

    // Frame 2: conversion, rounding and saturation boundaries.
    tgt_exp_i = 6'sd3;
    for (int i = 0; i < 16; i++) begin
      logic ss, k2;
      ss = (i % 4) == 0;
      k2 = ((i / 4) % 2) == 1;
      tick(i == 0, ss, 1'b1, 1'b0, k2, f2_re[i], f2_im[i], f2_ex[i], 1'b0,
           mk(1'b1, i == 0, i == 15, 1'b0, k2, f2_sat[i] == 1, 1'b0, i, f2_ere[i], f2_eim[i]));
    end
    repeat (3) idle(1'b0, 1'b0);

    // Frame 3: ldn=5 (S=8), stage_sync missing at idx 8.
    tgt_exp_i = 6'sd0;
    ldn_rg_i  = 4'd5;
    fr_std(32, 8, 8);
    repeat (2) idle(1'b0, 1'b1);
    // Clear together with a new error (stray block_sync): error stays.
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0));
    idle(1'b1, 1'b0);
    repeat (2) idle(1'b0, 1'b0);

    // Frame 4: ldn=4, block_sync again at idx 9 restarts the frame.
    ldn_rg_i = 4'd4;
    for (int j = 0; j < 25; j++) begin
      int   idx;
      logic bs, ss, k2;
      idx = (j < 9) ? j : j - 9;
      bs  = (j == 0) || (j == 9);
      ss  = (idx % 4) == 0;
      k2  = ((idx / 4) % 2) == 1;
      tick(bs, ss, 1'b1, 1'b0, k2, j * 100, -j, 0, 1'b0,
           mk(1'b1, bs, j == 24, 1'b0, k2, 1'b0, j >= 9, idx, j * 100, -j));
    end
    repeat (2) idle(1'b0, 1'b1);
    idle(1'b1, 1'b0);
    repeat (2) idle(1'b0, 1'b0);

    // Reset mid-frame after idx 0..5.
    for (int i = 0; i < 6; i++) begin
      logic ss;
      ss = (i % 4) == 0;
      tick(i == 0, ss, 1'b1, 1'b0, i >= 4, i + 1, i + 2, 0, 1'b0,
           mk(1'b1, i == 0, 1'b0, 1'b0, i >= 4, 1'b0, 1'b0, i, i + 1, i + 2));
    end
    @(posedge clk_sys);
    #1;
    rst_sys_n = 1'b0;
    data_val_i = 1'b0;
    block_sync_i = 1'b0;
    #1;
    chk_eq("midrst_val", data_val_o, 1'b0);
    chk_eq("midrst_sop", sop_o, 1'b0);
    chk_eq("midrst_err", sync_err_o, 1'b0);
    repeat (2) @(posedge clk_sys);
    @(posedge clk_sys);
    #1 rst_sys_n = 1'b1;
    p1 = '0;
    p2 = '0;
    // Samples without block_sync after reset are dropped.
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, (i % 4) == 0, 1'b1, 1'b0, 1'b0, 500 + i, -500, 0, 1'b0,
           mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0));
    end
    fr_std(16, 4, -1);
    repeat (3) idle(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/r4_stage_rx_align.md
Name: r4_stage_rx_align

Overview:
- Receive-side terminator for the radix-4 pipeline stage output stream (block_sync/next_sync/data_val/mantissa/exponent/k1/k2).
- Checks stream framing against the transform length and produces a sample index.
- Converts each block-floating-point sample to fixed point at a programmable target exponent, with symmetric rounding and saturation.
- Sits after the last butterfly unit and ahead of the output reorder memory / host interface.

Parameters:
- OUT_WIDTH, 16, output mantissa width (>= 4).
- Input mantissa width is `MAN_WIDTH; exponent width is `EXP_WIDTH (both from fixed_point.v).

Ports:
- clk_sys  in  1  system clock.
- rst_sys_n  in  1  reset: asynchronous, active-low; clock is clk_sys.
- block_sync_i  in  1  first sample of a transform frame; valid only with data_val_i.
- stage_sync_i  in  1  segment start (upstream next_sync).
- data_val_i  in  1  sample valid.
- data_real_i / data_imag_i  in  `MAN_WIDTH  signed mantissas.
- data_exp_i  in  `EXP_WIDTH  signed per-sample exponent.
- k1_i, k2_i  in  1  upstream segment flags.
- ldn_rg_i  in  4  log2 transform length, 4..11; static during a frame.
- tgt_exp_i  in  `EXP_WIDTH  signed target exponent; static during a frame.
- err_clr_i  in  1  clears sync_err_o.
- data_val_o  out  1  output valid.
- sop_o, eop_o  out  1  first / last sample of frame.
- data_real_o / data_imag_o  out  OUT_WIDTH  signed fixed-point result.
- sample_idx_o  out  11  arrival index within the frame.
- k1_o, k2_o  out  1  flags delayed to align with data.
- sat_o  out  1  either component of this sample saturated.
- sync_err_o  out  1  sticky framing error.

Behaviour:
- Reset: all outputs 0, idx counter 0, state IDLE.
- Latency: exactly 2 clk_sys cycles from data_val_i to data_val_o, no bubbles. Stage 1 registers the sample, index, flags and shift amount; stage 2 does round/saturate.
- Frame length N = 1<<ldn_rg_i. Segment length S = 4 when ldn is even, 8 when ldn is odd.
- FSM IDLE:
  - Samples with data_val_i are discarded.
  - data_val_i & block_sync_i -> idx=0, sop tagged, go RUN.
- FSM RUN:
  - Each valid sample gets the current idx; idx then increments.
  - Sample at idx==N-1 is tagged eop; go IDLE.
  - data_val_i & block_sync_i while idx!=0 -> restart at idx=0 with sop, set sync_err_o, no eop for the truncated frame.
- Framing checks, on valid samples in RUN only; any mismatch sets sync_err_o:
  - stage_sync_i must equal (idx mod S == 0).
  - k2_i must equal bit0 of (idx / S).
- sync_err_o is sticky. err_clr_i clears it; a simultaneous new error wins (stays 1).
- block_sync_i without data_val_i: ignored, sets sync_err_o.
- Conversion, per component, with sh = tgt_exp_i - data_exp_i computed in `EXP_WIDTH+1 bits:
  - sh > 0: arithmetic right shift by sh, rounding half away from zero (SYMRND). sh >= `MAN_WIDTH+1 gives 0.
  - sh <= 0: left shift by -sh.
  - Result saturates symmetrically to +/-(2^(OUT_WIDTH-1)-1); -2^(OUT_WIDTH-1) is never output.
  - A zero mantissa never saturates.
- sat_o = OR of both component saturation events.
- Reset mid-frame: pipeline flushed, state IDLE; samples discarded until the next block_sync_i.

Optional Feature:
- FFT_RX_SATCNT_EN defined: adds output sat_cnt_o (12 bits).
  - Counts samples with sat_o within a frame, saturating at 4095.
  - Latched on the eop output cycle and held until the next eop.
  - Internal counter clears on sop.
  - Reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package holds:
  - S lookup from ldn (4/8), shared with the butterfly units.
  - N = 1<<ldn.
  - SYMRND macro and MAN/EXP widths (existing macros.v/fixed_point.v).
- One sub-module: bfp_shift_sat.
  - Single component: mantissa + signed shift in, OUT_WIDTH result + sat flag out, combinational.
  - Instanced twice (real/imag) in stage 2.

Test Plan:
(Bench configuration: `MAN_WIDTH=16, `EXP_WIDTH=6, OUT_WIDTH=16.)
- ldn=4, tgt=exp=0, 16 valid samples; block_sync on sample 0; stage_sync at idx 0,4,8,12; k2 pattern 0,1,0,1 per segment -> outputs 2 cycles later, sop at idx0, eop at idx15, data unchanged, sync_err_o=0.
- tgt=3, exp=1: real=7 -> 2, real=-6 -> -2, imag=5 -> 1 (1.25), imag=-2 -> -1 (-0.5 away from zero); sat_o=0.
- tgt=0, exp=2: real=10000 -> 32767, imag=-10000 -> -32767, sat_o=1. Same exp with real=0, imag=3 -> 0, 12, sat_o=0.
- ldn=5 (S=8), stage_sync omitted at idx8 -> sync_err_o=1 from that sample on; err_clr_i pulse with no new error -> 0 next cycle.
- ldn=4, block_sync at idx9 -> that sample out with idx0/sop, sync_err_o=1, no eop before the new frame's idx15.
- Assert rst_sys_n low at idx6, release, feed 5 samples without block_sync -> data_val_o stays 0; a following block_sync frame is processed normally from idx0.
